// File: rtl/stream_demux_1xn.sv
// stream_demux_1xn: registered 1-to-N stream demux with unicast, broadcast and out-of-range drop
module stream_demux_1xn #(
  parameter int DATA_W = 8,
  parameter int N_OUT = 4,
  localparam int SEL_W = N_OUT > 1 ? $clog2(N_OUT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  input  logic [SEL_W-1:0]        s_sel,
  input  logic                    s_bcast,
  output logic [N_OUT-1:0]        m_valid,
  input  logic [N_OUT-1:0]        m_ready,
  output logic [N_OUT*DATA_W-1:0] m_data,
  output logic                    err_sel
);
  logic [N_OUT-1:0] free, hit, wr;
  logic in_range, xfer, err_n;
  always_comb begin
    free = ~m_valid | m_ready;
    in_range = {1'b0, s_sel} < (SEL_W+1)'(N_OUT);
    for (int k = 0; k < N_OUT; k++) hit[k] = in_range && s_sel == SEL_W'(k);
    // out-of-range words are always accepted so they can be dropped
    s_ready = ~rst & (s_bcast ? &free : (in_range ? |(hit & free) : 1'b1));
    xfer = s_valid & s_ready;
    wr = xfer ? (s_bcast ? '1 : hit) : '0;
    err_n = xfer & ~s_bcast & ~in_range;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= '0;
      m_data <= '0;
      err_sel <= 1'b0;
    end else begin
      err_sel <= err_n;
      for (int k = 0; k < N_OUT; k++) begin
        if (wr[k]) begin
          m_valid[k] <= 1'b1;
          m_data[k*DATA_W +: DATA_W] <= s_data;
        end else if (m_valid[k] && m_ready[k]) begin
          m_valid[k] <= 1'b0;
          m_data[k*DATA_W +: DATA_W] <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_stream_demux_1xn.sv
// tb_stream_demux_1xn: vector table on a 4-channel instance, hand sequences and random model check on a 3-channel instance
module tb_stream_demux_1xn;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic s_valid = 1'b0, s_bcast = 1'b0, s_ready, err_sel;
  logic [7:0] s_data = 8'h00;
  logic [1:0] s_sel = 2'd0;
  logic [3:0] m_valid, m_ready = 4'h0;
  logic [31:0] m_data;

  logic s3_valid = 1'b0, s3_bcast = 1'b0, s3_ready, err3;
  logic [7:0] s3_data = 8'h00;
  logic [1:0] s3_sel = 2'd0;
  logic [2:0] m3_valid, m3_ready = 3'h0;
  logic [23:0] m3_data;

  stream_demux_1xn #(.DATA_W(8), .N_OUT(4)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sel(s_sel), .s_bcast(s_bcast), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .err_sel(err_sel));

  stream_demux_1xn #(.DATA_W(8), .N_OUT(3)) dut3 (
    .clk(clk), .rst(rst), .s_valid(s3_valid), .s_ready(s3_ready), .s_data(s3_data),
    .s_sel(s3_sel), .s_bcast(s3_bcast), .m_valid(m3_valid), .m_ready(m3_ready),
    .m_data(m3_data), .err_sel(err3));

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic rst, v;
    logic [7:0] d;
    logic [1:0] sel;
    logic bc;
    logic [3:0] mr;
    logic rdy;
    logic [3:0] mv;
    logic [31:0] md;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic [1:0] sel,
                     input logic bc, input logic [3:0] mr, input logic rdy, input logic [3:0] mv,
                     input logic [31:0] md);
    vec_t t;
    t.rst = r; t.v = v; t.d = d; t.sel = sel; t.bc = bc; t.mr = mr;
    t.rdy = rdy; t.mv = mv; t.md = md;
    tv.push_back(t);
  endtask

  task automatic drive3(input logic v, input logic [7:0] d, input logic [1:0] sel,
                        input logic bc, input logic [2:0] mr);
    s3_valid = v; s3_data = d; s3_sel = sel; s3_bcast = bc; m3_ready = mr;
  endtask

  bit full[3];
  logic [7:0] val[3];
  logic exp_err;

  task automatic model_cycle(input logic r, input logic v, input logic [7:0] d,
                             input logic [1:0] sel, input logic bc, input logic [2:0] mr);
    bit fr[3];
    bit all_free, rdy, acc;
    rst = r;
    drive3(v, d, sel, bc, mr);
    #1;
    all_free = 1;
    for (int k = 0; k < 3; k++) begin
      fr[k] = !full[k] || mr[k];
      all_free &= fr[k];
    end
    rdy = r ? 0 : bc ? all_free : (sel < 3 ? fr[sel] : 1);
    chk("rnd_s_ready", {31'd0, s3_ready}, {31'd0, rdy});
    @(posedge clk);
    acc = v && rdy;
    for (int k = 0; k < 3; k++) begin
      if (r) begin full[k] = 0; val[k] = 8'h00; end
      else if (acc && (bc || sel == k)) begin full[k] = 1; val[k] = d; end
      else if (full[k] && mr[k]) begin full[k] = 0; val[k] = 8'h00; end
    end
    exp_err = !r && acc && !bc && sel >= 3;
    #1;
    chk("rnd_m_valid", {29'd0, m3_valid}, {29'd0, full[2], full[1], full[0]});
    chk("rnd_m_data", {8'd0, m3_data}, {8'd0, val[2], val[1], val[0]});
    chk("rnd_err_sel", {31'd0, err3}, {31'd0, exp_err});
  endtask

  initial begin
    // reset with s_valid high
    add(1'b1, 1'b1, 8'h99, 2'd0, 1'b0, 4'hF, 1'b0, 4'h0, 32'h0);
    add(1'b1, 1'b1, 8'h99, 2'd0, 1'b0, 4'hF, 1'b0, 4'h0, 32'h0);
    // unicast sweep
    add(1'b0, 1'b1, 8'hA0, 2'd0, 1'b0, 4'hF, 1'b1, 4'b0001, 32'h000000A0);
    add(1'b0, 1'b1, 8'hA1, 2'd1, 1'b0, 4'hF, 1'b1, 4'b0010, 32'h0000A100);
    add(1'b0, 1'b1, 8'hA2, 2'd2, 1'b0, 4'hF, 1'b1, 4'b0100, 32'h00A20000);
    add(1'b0, 1'b1, 8'hA3, 2'd3, 1'b0, 4'hF, 1'b1, 4'b1000, 32'hA3000000);
    add(1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 1'b1, 4'b0000, 32'h00000000);
    // stall isolation on ch2
    add(1'b0, 1'b1, 8'h11, 2'd2, 1'b0, 4'b1011, 1'b1, 4'b0100, 32'h00110000);
    add(1'b0, 1'b1, 8'h22, 2'd2, 1'b0, 4'b1011, 1'b0, 4'b0100, 32'h00110000);
    add(1'b0, 1'b1, 8'h33, 2'd1, 1'b0, 4'b1011, 1'b1, 4'b0110, 32'h00113300);
    add(1'b0, 1'b1, 8'h22, 2'd2, 1'b0, 4'hF, 1'b1, 4'b0100, 32'h00220000);
    add(1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 4'hF, 1'b1, 4'b0000, 32'h00000000);
    // broadcast all-or-nothing
    add(1'b0, 1'b1, 8'h77, 2'd3, 1'b0, 4'b0111, 1'b1, 4'b1000, 32'h77000000);
    add(1'b0, 1'b1, 8'h5A, 2'd0, 1'b1, 4'b0111, 1'b0, 4'b1000, 32'h77000000);
    add(1'b0, 1'b1, 8'h5A, 2'd0, 1'b1, 4'hF, 1'b1, 4'b1111, 32'h5A5A5A5A);
    // drain+refill without bubble, then mid-stream reset
    add(1'b0, 1'b1, 8'h10, 2'd0, 1'b0, 4'hF, 1'b1, 4'b0001, 32'h00000010);
    add(1'b0, 1'b1, 8'h20, 2'd0, 1'b0, 4'b0001, 1'b1, 4'b0001, 32'h00000020);
    add(1'b0, 1'b1, 8'h30, 2'd1, 1'b0, 4'b0000, 1'b1, 4'b0011, 32'h00003020);
    add(1'b1, 1'b1, 8'h44, 2'd1, 1'b0, 4'b0000, 1'b0, 4'b0000, 32'h00000000);
    add(1'b0, 1'b0, 8'h00, 2'd1, 1'b0, 4'hF, 1'b1, 4'b0000, 32'h00000000);

    @(posedge clk); #1;
    foreach (tv[i]) begin
      rst = tv[i].rst; s_valid = tv[i].v; s_data = tv[i].d; s_sel = tv[i].sel;
      s_bcast = tv[i].bc; m_ready = tv[i].mr;
      #1;
      chk($sformatf("vec%0d_s_ready", i), {31'd0, s_ready}, {31'd0, tv[i].rdy});
      @(posedge clk); #1;
      chk($sformatf("vec%0d_m_valid", i), {28'd0, m_valid}, {28'd0, tv[i].mv});
      chk($sformatf("vec%0d_m_data", i), m_data, tv[i].md);
      chk($sformatf("vec%0d_err_sel", i), {31'd0, err_sel}, 32'd0);
    end
    rst = 1'b0; s_valid = 1'b0;

    // out-of-range drops on the 3-channel instance: single, then back-to-back
    drive3(1'b1, 8'hFF, 2'd3, 1'b0, 3'b111);
    #1 chk("oor_s_ready", {31'd0, s3_ready}, 32'd1);
    @(posedge clk); #1;
    chk("oor_err1", {31'd0, err3}, 32'd1);
    chk("oor_no_valid", {29'd0, m3_valid}, 32'd0);
    drive3(1'b0, 8'h00, 2'd3, 1'b0, 3'b111);
    @(posedge clk); #1;
    chk("oor_err_pulse_end", {31'd0, err3}, 32'd0);
    drive3(1'b1, 8'hEE, 2'd3, 1'b0, 3'b111);
    @(posedge clk); #1;
    chk("oor_b2b_1", {31'd0, err3}, 32'd1);
    @(posedge clk); #1;
    chk("oor_b2b_2", {31'd0, err3}, 32'd1);
    drive3(1'b1, 8'hC2, 2'd2, 1'b0, 3'b000);
    @(posedge clk); #1;
    chk("oor_b2b_end", {31'd0, err3}, 32'd0);
    chk("n3_ch2_valid", {29'd0, m3_valid}, 32'h4);
    chk("n3_ch2_data", {8'd0, m3_data}, 32'h00C20000);
    drive3(1'b0, 8'h00, 2'd0, 1'b0, 3'b000);

    // randomized traffic against the reference model, starting from reset
    for (int k = 0; k < 3; k++) begin full[k] = 0; val[k] = 8'h00; end
    model_cycle(1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 3'b000);
    for (int i = 0; i < 400; i++)
      model_cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
                  2'($urandom), $urandom_range(0, 7) == 0, 3'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
